// File: rtl/seg_scanner.sv
// Four-digit multiplexed seven-segment driver with frame-aligned double buffering.
// The FASTCLK toggle is treated purely as a step event sampled on CLOCK.

module seg_lane (
    input  logic [3:0] nib,
    input  logic       dpen,
    output logic [6:0] seg,
    output logic       nz
);
    // nz marks a digit that must stay lit and stops leading-zero blanking below it
    assign nz = (nib != 4'h0) || dpen;

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module seg_scanner #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        FASTCLK,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    input  logic        BLANK,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);
    localparam int NUM_DIG = 4;

    logic                        fq;
    logic                        step;
    logic                        wrap;
    logic [1:0]                  digit;
    logic [15:0]                 pv;
    logic [15:0]                 av;
    logic [3:0]                  pd;
    logic [3:0]                  ad;
    logic                        pvalid;
    logic [1:0]                  vld_pipe;
    logic [NUM_DIG-1:0][3:0]     nib;
    logic [NUM_DIG-1:0][6:0]     dseg;
    logic [NUM_DIG-1:0]          nz;
    logic [NUM_DIG-1:0]          blank;

    assign step = FASTCLK ^ fq;
    assign wrap = step && (digit == 2'd3);
    assign nib  = av;

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_lane
            seg_lane u_lane (
                .nib  (nib[g]),
                .dpen (ad[g]),
                .seg  (dseg[g]),
                .nz   (nz[g])
            );
            // a digit is dark only if it and every digit above it are zero with no DP
            if (g == 0) begin : g_d0
                assign blank[g] = 1'b0;
            end else begin : g_dn
                assign blank[g] = LZ_BLANK & ~|nz[NUM_DIG-1:g];
            end
        end
    endgenerate

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fq     <= 1'b0;
            digit  <= 2'd0;
            pv     <= '0;
            pd     <= '0;
            pvalid <= 1'b0;
            av     <= '0;
            ad     <= '0;
        end else begin
            fq <= FASTCLK;
            if (step)
                digit <= digit + 2'd1;
            // a LOAD coinciding with the transfer refills pending after it drains
            if (LOAD) begin
                pv     <= VALUE;
                pd     <= DP;
                pvalid <= 1'b1;
            end else if (wrap && pvalid) begin
                pvalid <= 1'b0;
            end
            if (wrap && pvalid) begin
                av <= pv;
                ad <= pd;
            end
        end
    end

    // frame is delayed twice so it lines up with the first display of new digit-0 data
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            vld_pipe <= '0;
            an       <= 4'hF;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else begin
            vld_pipe <= {vld_pipe[0], wrap};
            if (BLANK || blank[digit]) begin
                an  <= 4'hF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << digit);
                seg <= dseg[digit];
                dp  <= ~ad[digit];
            end
        end
    end

    assign frame = vld_pipe[1];
endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: a frame-level display model checked every cycle,
// plus directed scenarios with hand-computed segment patterns.

module tb_seg_scanner;
    logic        CLOCK;
    logic        RESET;
    logic        FASTCLK;
    logic [15:0] VALUE;
    logic [3:0]  DP;
    logic        LOAD;
    logic        BLANK;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    seg_scanner #(.LZ_BLANK(1'b1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .FASTCLK(FASTCLK), .VALUE(VALUE), .DP(DP),
        .LOAD(LOAD), .BLANK(BLANK), .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int frames = 0;
    int F, F1, F2, fsnap;
    bit chk_en = 0;
    bit scan_on = 0;

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) cyc++;
    always @(negedge CLOCK) if (frame === 1'b1) frames++;

    // FASTCLK source: toggles every 8 cycles while scanning is enabled
    initial begin
        int tcnt;
        tcnt = 0;
        FASTCLK = 0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!scan_on) begin
                FASTCLK = 0;
                tcnt = 0;
            end else begin
                tcnt++;
                if (tcnt == 8) begin
                    FASTCLK = ~FASTCLK;
                    tcnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Display rule: the highest digit that is nonzero or has its DP set, and all below, are lit.
    function automatic void disp(input int d, input logic [15:0] v, input logic [3:0] p,
                                 input logic blk, output logic [3:0] a, output logic [6:0] s,
                                 output logic dpo);
        int first;
        first = 0;
        for (int k = 3; k >= 1; k--)
            if (first == 0 && (v[k*4 +: 4] != 4'h0 || p[k])) first = k;
        a = 4'hF;
        s = 7'h7F;
        dpo = 1'b1;
        if (!blk && d <= first) begin
            a[d] = 1'b0;
            s = HEX[v[d*4 +: 4]];
            dpo = ~p[d];
        end
    endfunction

    // model state
    logic        m_fq, m_pval;
    int          m_steps, m_prev;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    always @(posedge CLOCK) begin
        int cur;
        if (RESET) begin
            m_fq = 0; m_pval = 0; m_steps = 0; m_prev = 0;
            m_pv = 0; m_av = 0; m_pd = 0; m_ad = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_frame = 0;
        end else begin
            cur = m_steps % 4;
            disp(cur, m_av, m_ad, BLANK, e_an, e_seg, e_dp);
            e_frame = (cur == 0 && m_prev == 3);
            m_prev = cur;
            if (FASTCLK !== m_fq) begin
                if (cur == 3 && m_pval) begin
                    m_av = m_pv; m_ad = m_pd; m_pval = 0;
                end
                m_steps++;
            end
            m_fq = FASTCLK;
            if (LOAD) begin
                m_pv = VALUE; m_pd = DP; m_pval = 1;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            if (RESET) begin
                chk("rst_an", an, 4'hF);
                chk("rst_seg", seg, 7'h7F);
                chk("rst_dp", dp, 1'b1);
                chk("rst_frame", frame, 1'b0);
            end else begin
                chk("an", an, e_an);
                chk("seg", seg, e_seg);
                chk("dp", dp, e_dp);
                chk("frame", frame, e_frame);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge CLOCK);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        VALUE = v; DP = d; LOAD = 1;
        @(negedge CLOCK);
        LOAD = 0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge CLOCK);
        while (frame !== 1'b1 && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        chk("frame_wait", frame, 1'b1);
        F = cyc;
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
        chk({name, "_an"}, an, a);
        chk({name, "_seg"}, seg, s);
        chk({name, "_dp"}, dp, d);
    endtask

    initial begin
        RESET = 1; VALUE = 0; DP = 0; LOAD = 0; BLANK = 0;
        @(negedge CLOCK);
        chk_en = 1;
        repeat (2) @(negedge CLOCK);
        lit("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_frame", frame, 1'b0);
        RESET = 0;
        @(negedge CLOCK);
        lit("first", 4'hE, 7'h40, 1'b1);
        repeat (20) @(negedge CLOCK);
        lit("idle", 4'hE, 7'h40, 1'b1);
        chk("idle_frames", frames, 0);

        // 12AF with DP on digit 2
        pulse_load(16'h12AF, 4'b0100);
        scan_on = 1;
        wait_frame();
        lit("s12af_d0", 4'hE, 7'h0E, 1'b1);
        goto(F + 10); lit("s12af_d1", 4'hD, 7'h08, 1'b1);
        goto(F + 18); lit("s12af_d2", 4'hB, 7'h24, 1'b0);
        goto(F + 26); lit("s12af_d3", 4'h7, 7'h79, 1'b1);
        wait_frame(); F1 = F;
        wait_frame(); F2 = F;
        chk("frame_period", F2 - F1, 32);

        // leading-zero blanking
        pulse_load(16'h0005, 4'b0000);
        wait_frame();
        lit("lz_d0", 4'hE, 7'h12, 1'b1);
        goto(F + 10); lit("lz_d1", 4'hF, 7'h7F, 1'b1);
        goto(F + 18); lit("lz_d2", 4'hF, 7'h7F, 1'b1);
        goto(F + 26); lit("lz_d3", 4'hF, 7'h7F, 1'b1);
        pulse_load(16'h0005, 4'b0100);
        wait_frame();
        lit("lzdp_d0", 4'hE, 7'h12, 1'b1);
        goto(F + 10); lit("lzdp_d1", 4'hD, 7'h40, 1'b1);
        goto(F + 18); lit("lzdp_d2", 4'hB, 7'h40, 1'b0);
        goto(F + 26); lit("lzdp_d3", 4'hF, 7'h7F, 1'b1);

        // anti-tear: loads mid-frame only show from the next wrap
        wait_frame();
        goto(F + 9);  pulse_load(16'h1111, 4'b0000);
        goto(F + 17); pulse_load(16'h2222, 4'b0000);
        goto(F + 26); lit("tear_d3_old", 4'hF, 7'h7F, 1'b1);
        wait_frame();
        lit("at_d0", 4'hE, 7'h24, 1'b1);
        goto(F + 10); lit("at_d1", 4'hD, 7'h24, 1'b1);
        goto(F + 18); lit("at_d2", 4'hB, 7'h24, 1'b1);
        goto(F + 26); lit("at_d3", 4'h7, 7'h24, 1'b1);

        // LOAD coinciding with the wrap edge
        goto(F + 5);  pulse_load(16'h3333, 4'b0000);
        goto(F + 30); pulse_load(16'h4444, 4'b0000);
        wait_frame();
        lit("wrap_prior", 4'hE, 7'h30, 1'b1);
        wait_frame();
        lit("wrap_new", 4'hE, 7'h19, 1'b1);

        // BLANK across a wrap
        goto(F + 20); fsnap = frames; BLANK = 1;
        goto(F + 21); lit("blank_on", 4'hF, 7'h7F, 1'b1);
        goto(F + 30); lit("blank_mid", 4'hF, 7'h7F, 1'b1);
        goto(F + 40); BLANK = 0;
        lit("blank_last", 4'hF, 7'h7F, 1'b1);
        goto(F + 41); lit("blank_off", 4'hD, 7'h19, 1'b1);
        chk("blank_frames", frames - fsnap, 1);

        // reset mid-frame with a pending load
        pulse_load(16'h5555, 4'b0000);
        goto(F + 50);
        scan_on = 0;
        #3 RESET = 1;
        #1 lit("midrst", 4'hF, 7'h7F, 1'b1);
        chk("midrst_frame", frame, 1'b0);
        repeat (3) @(negedge CLOCK);
        RESET = 0;
        @(negedge CLOCK);
        lit("post_rst", 4'hE, 7'h40, 1'b1);
        scan_on = 1;
        wait_frame();
        lit("post_f1", 4'hE, 7'h40, 1'b1);
        wait_frame();
        lit("post_f2", 4'hE, 7'h40, 1'b1);

        repeat (4) @(negedge CLOCK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
